mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported external memory between instruction fetch and data load/store.
// Optional access timeout with sticky bus_err is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic        ext_ack,
    input  logic [31:0] ext_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        i_done_r, i_done_s;
    logic        d_done_r, d_done_s;
    logic        ext_req_r, ext_req_s;
    logic        ext_we_r, ext_we_s;
    logic [31:0] ext_addr_r, ext_addr_s;
    logic [31:0] ext_wdata_r, ext_wdata_s;
    logic [31:0] inst_data_r, inst_data_s;
    logic [31:0] mem_din_r, mem_din_s;
    logic        dreq_s, i_pend_s, d_pend_s, stall_s;
    logic        enter_s, expire_s, done_s;
    logic [31:0] rdata_s;

    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("mem_port_arbiter: TIMEOUT must be within 1..255");
    end

    assign dreq_s   = mem_ren | mem_wen;
    assign i_pend_s = inst_ren & ~i_done_r;
    assign d_pend_s = dreq_s & ~d_done_r;
    assign stall_s  = i_pend_s | d_pend_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_r;
    logic       bus_err_r;

    // An expiry is an ack-less cycle that ends the TIMEOUT-th cycle of the access.
    assign expire_s = (state_r != ST_IDLE) & ~ext_ack & (cnt_r == TO_LAST);
    assign done_s   = ext_ack | expire_s;
    assign rdata_s  = ext_ack ? ext_rdata : 32'hFFFF_FFFF;
    assign bus_err  = bus_err_r;

    // Cycles spent in the current access; restarts whenever a new access is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (enter_s) begin
            cnt_r <= 8'd0;
        end else if (state_r != ST_IDLE) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else if (expire_s) begin
            bus_err_r <= 1'b1;
        end
    end
`else
    assign expire_s = 1'b0;
    assign done_s   = ext_ack;
    assign rdata_s  = ext_rdata;
    assign bus_err  = 1'b0;
`endif

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_s     = state_r;
        i_done_s    = i_done_r;
        d_done_s    = d_done_r;
        ext_req_s   = ext_req_r;
        ext_we_s    = ext_we_r;
        ext_addr_s  = ext_addr_r;
        ext_wdata_s = ext_wdata_r;
        inst_data_s = inst_data_r;
        mem_din_s   = mem_din_r;
        enter_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!stall_s) begin
                    // Advance edge: pipeline moves on, nothing new is launched here.
                    i_done_s = 1'b0;
                    d_done_s = 1'b0;
                end else if (d_pend_s) begin
                    state_s     = ST_DATA;
                    enter_s     = 1'b1;
                    ext_req_s   = 1'b1;
                    ext_we_s    = mem_wen;
                    ext_addr_s  = mem_addr;
                    ext_wdata_s = mem_dout;
                end else begin
                    state_s    = ST_INST;
                    enter_s    = 1'b1;
                    ext_req_s  = 1'b1;
                    ext_we_s   = 1'b0;
                    ext_addr_s = inst_addr;
                end
            end
            ST_DATA: begin
                if (done_s) begin
                    d_done_s  = 1'b1;
                    ext_req_s = 1'b0;
                    ext_we_s  = 1'b0;
                    if (!mem_wen) begin
                        mem_din_s = rdata_s;
                    end else begin
                        mem_din_s = mem_din_r;
                    end
                    // Chain straight into the fetch so ext_req never drops in between.
                    if (i_pend_s) begin
                        state_s    = ST_INST;
                        enter_s    = 1'b1;
                        ext_req_s  = 1'b1;
                        ext_addr_s = inst_addr;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_INST: begin
                if (done_s) begin
                    i_done_s    = 1'b1;
                    ext_req_s   = 1'b0;
                    ext_we_s    = 1'b0;
                    inst_data_s = rdata_s;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_INST;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                ext_req_s = 1'b0;
                ext_we_s  = 1'b0;
            end
        endcase
    end

    // State, done flags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            i_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            ext_req_r   <= 1'b0;
            ext_we_r    <= 1'b0;
            ext_addr_r  <= 32'd0;
            ext_wdata_r <= 32'd0;
            inst_data_r <= 32'd0;
            mem_din_r   <= 32'd0;
        end else begin
            state_r     <= state_s;
            i_done_r    <= i_done_s;
            d_done_r    <= d_done_s;
            ext_req_r   <= ext_req_s;
            ext_we_r    <= ext_we_s;
            ext_addr_r  <= ext_addr_s;
            ext_wdata_r <= ext_wdata_s;
            inst_data_r <= inst_data_s;
            mem_din_r   <= mem_din_s;
        end
    end

    assign mem_stall = stall_s;
    assign ext_req   = ext_req_r;
    assign ext_we    = ext_we_r;
    assign ext_addr  = ext_addr_r;
    assign ext_wdata = ext_wdata_r;
    assign inst_data = inst_data_r;
    assign mem_din   = mem_din_r;

endmodule
